// File: rtl/weight_bram_writer.sv
// Packs a narrow valid/ready stream LSB-first into wide weight lines and
// writes write_length consecutive lines from base_address through one BRAM port.
module weight_bram_writer #(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int IN_WIDTH           = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] base_address,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] write_length,
  input  logic [IN_WIDTH-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_address,
  output logic [5*MAC_NUM-1:0]          bram_din,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic                          busy,
  output logic                          done,
  output logic [BRAM_ADDRESS_WIDTH:0]   lines_written
);

  localparam int W      = BRAM_ADDRESS_WIDTH;
  localparam int LINE_W = 5 * MAC_NUM;
  localparam int BEATS  = LINE_W / IN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [W-1:0]        addr_q, addr_d;
  logic [W-1:0]        len_q, len_d;
  logic [W:0]          lines_q, lines_d;
  logic [LINE_W-1:0]   pack_q, pack_d;
  logic                s_ready_q, s_ready_d;
  logic [W-1:0]        bram_address_q, bram_address_d;
  logic [LINE_W-1:0]   bram_din_q, bram_din_d;
  logic                bram_en_q, bram_en_d;
  logic                bram_we_q, bram_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_s;
  logic [LINE_W-1:0]   pack_next_s;

  // Next-state, packing and registered-output decode.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    addr_d         = addr_q;
    len_d          = len_q;
    lines_d        = lines_q;
    pack_d         = pack_q;
    bram_address_d = bram_address_q;
    bram_din_d     = bram_din_q;
    accept_s       = s_valid & s_ready_q;
    pack_next_s    = pack_q;

    // Merge the accepted beat into its slot so the final beat can go straight to the BRAM register.
    for (int i = 0; i < BEATS; i++) begin
      if (accept_s && (beat_q == BEAT_W'(i))) begin
        pack_next_s[i*IN_WIDTH +: IN_WIDTH] = s_data;
      end else begin
        pack_next_s[i*IN_WIDTH +: IN_WIDTH] = pack_q[i*IN_WIDTH +: IN_WIDTH];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_address;
          len_d   = write_length;
          lines_d = '0;
          if (write_length != '0) begin
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s) begin
          pack_d = pack_next_s;
          if (beat_q == LAST_BEAT) begin
            beat_d         = '0;
            state_d        = S_WRITE;
            bram_din_d     = pack_next_s;
            bram_address_d = addr_q;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        lines_d = lines_q + 1'b1;
        if ((lines_q + 1'b1) < {1'b0, len_q}) begin
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d = (state_d == S_FILL);
    bram_en_d = (state_d == S_WRITE);
    bram_we_d = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      beat_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      lines_q        <= '0;
      pack_q         <= '0;
      s_ready_q      <= 1'b0;
      bram_address_q <= '0;
      bram_din_q     <= '0;
      bram_en_q      <= 1'b0;
      bram_we_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      lines_q        <= lines_d;
      pack_q         <= pack_d;
      s_ready_q      <= s_ready_d;
      bram_address_q <= bram_address_d;
      bram_din_q     <= bram_din_d;
      bram_en_q      <= bram_en_d;
      bram_we_q      <= bram_we_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign bram_address  = bram_address_q;
  assign bram_din      = bram_din_q;
  assign bram_en       = bram_en_q;
  assign bram_we       = bram_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_written = lines_q;

endmodule

// File: tb/tb_weight_bram_writer.sv
// Self-checking bench for weight_bram_writer: expected lines are assembled from
// the beat sequence the bench offers, expected addresses from base+i modulo 2^W.
module tb_weight_bram_writer;

  localparam int W  = 12;
  localparam int LW = 1280;
  localparam int IW = 64;
  localparam int NB = 20;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst_n, start, s_valid, s_ready;
  logic [W-1:0]  base_address, write_length, bram_address;
  logic [IW-1:0] s_data;
  logic [LW-1:0] bram_din;
  logic          bram_en, bram_we, busy, done;
  logic [W:0]    lines_written;

  always #5 clk = ~clk;

  weight_bram_writer #(.MAC_NUM(256), .BRAM_ADDRESS_WIDTH(W), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address),
    .write_length(write_length), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bram_address(bram_address), .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we),
    .busy(busy), .done(done), .lines_written(lines_written)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cyc;
  int acc_cnt, rdy_cnt, en_cnt, last_acc_cyc;
  logic [W-1:0]  wr_addr[$];
  logic [LW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            done_cyc[$];
  logic [IW-1:0] seq[0:127];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observe outputs and handshakes mid-cycle.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wr_addr.push_back(bram_address);
      wr_data.push_back(bram_din);
      wr_cyc.push_back(cyc);
    end
    if (bram_en === 1'b1) en_cnt <= en_cnt + 1;
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (s_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    acc_cnt = 0; rdy_cnt = 0; en_cnt = 0; last_acc_cyc = -1;
  endtask

  task automatic fill_seq(input bit use_index);
    for (int k = 0; k < 128; k++) seq[k] = use_index ? IW'(k) : {$urandom, $urandom};
  endtask

  function automatic logic [LW-1:0] exp_line(input int line);
    logic [LW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*IW +: IW] = seq[line*NB + k];
    return r;
  endfunction

  function automatic int diff_beat(input logic [LW-1:0] a, input logic [LW-1:0] b);
    for (int k = 0; k < NB; k++) if (a[k*IW +: IW] !== b[k*IW +: IW]) return k;
    return 0;
  endfunction

  function automatic logic [LW-1:0] got_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : '0;
  endfunction

  function automatic logic [W-1:0] got_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 12'hBAD;
  endfunction

  function automatic int got_wcyc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  function automatic int got_dcyc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  // Issues one command and streams seq[] until done (or stop_after beats, or the budget expires).
  task automatic run_cmd(input logic [W-1:0] base, input logic [W-1:0] len, input int mode,
                         input int stop_after, input bit mid_start, output bit tmo);
    int j, n, d0;
    bit hs, pulsed;
    j = 0; n = 0; pulsed = 1'b0; tmo = 1'b0; d0 = done_cyc.size();
    @(posedge clk); #1;
    start = 1'b1; base_address = base; write_length = len;
    s_valid = 1'b1; s_data = seq[0]; start_cyc = cyc;
    while (1) begin
      @(negedge clk); hs = (s_valid === 1'b1) && (s_ready === 1'b1);
      @(posedge clk); #1;
      start = 1'b0; n++;
      if (hs) j++;
      if (stop_after >= 0 && j >= stop_after) break;
      if (done_cyc.size() > d0) break;
      if (n >= BUDGET) begin tmo = 1'b1; break; end
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (n % 3 != 0);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = (j < 128) ? seq[j] : {$urandom, $urandom};
      if (mid_start && !pulsed && j == 5) begin
        start = 1'b1; base_address = 12'h200; write_length = 12'd3; pulsed = 1'b1;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    if (stop_after < 0) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit tmo;
    fill_seq(1'b0); clear_log();
    run_cmd(12'($urandom), 12'd2, 2, 5, 1'b0, tmo);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tmo !== 1'b0) $display("FAIL reset_setup: timeout"); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b exp 0", s_ready); else passed++;
    checks++; if (bram_en !== 1'b0) $display("FAIL reset_en: got %b exp 0", bram_en); else passed++;
    checks++; if (bram_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", bram_we); else passed++;
    checks++; if (bram_address !== '0) $display("FAIL reset_addr: got %h exp 0", bram_address); else passed++;
    checks++; if (bram_din !== '0) $display("FAIL reset_din: got nonzero beat %0d exp 0", diff_beat(bram_din, '0)); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else passed++;
    checks++; if (lines_written !== '0) $display("FAIL reset_lines: got %0d exp 0", lines_written); else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_single_line();
    bit tmo;
    logic [LW-1:0] e;
    fill_seq(1'b1); clear_log();
    run_cmd(12'h010, 12'd1, 0, -1, 1'b0, tmo);
    e = exp_line(0);
    checks++; if (tmo !== 1'b0) $display("FAIL single_timeout: no done"); else passed++;
    checks++; if (wr_addr.size() != 1) $display("FAIL single_nwrites: got %0d exp 1", wr_addr.size()); else passed++;
    checks++; if (got_addr(0) !== 12'h010) $display("FAIL single_addr: got %h exp 010", got_addr(0)); else passed++;
    checks++; if (got_data(0) !== e) $display("FAIL single_din beat %0d: got %h exp %h", diff_beat(got_data(0), e),
      got_data(0)[diff_beat(got_data(0), e)*IW +: IW], e[diff_beat(got_data(0), e)*IW +: IW]); else passed++;
    checks++; if (rdy_cnt != NB) $display("FAIL single_ready_cycles: got %0d exp %0d", rdy_cnt, NB); else passed++;
    checks++; if (got_wcyc(0) != start_cyc + 21) $display("FAIL single_write_cycle: got %0d exp %0d", got_wcyc(0), start_cyc + 21); else passed++;
    checks++; if (got_dcyc(0) != start_cyc + 22) $display("FAIL single_done_cycle: got %0d exp %0d", got_dcyc(0), start_cyc + 22); else passed++;
    checks++; if (lines_written !== 13'd1) $display("FAIL single_lines: got %0d exp 1", lines_written); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    bit tmo;
    logic [LW-1:0] e;
    fill_seq(1'b0); clear_log();
    run_cmd(12'h010, 12'd1, 1, -1, 1'b0, tmo);
    e = exp_line(0);
    checks++; if (tmo !== 1'b0) $display("FAIL bp_timeout: no done"); else passed++;
    checks++; if (acc_cnt != NB) $display("FAIL bp_accepted: got %0d exp %0d", acc_cnt, NB); else passed++;
    checks++; if (got_data(0) !== e) $display("FAIL bp_din beat %0d: got %h exp %h", diff_beat(got_data(0), e),
      got_data(0)[diff_beat(got_data(0), e)*IW +: IW], e[diff_beat(got_data(0), e)*IW +: IW]); else passed++;
    checks++; if (got_wcyc(0) != last_acc_cyc + 1) $display("FAIL bp_latency: got %0d exp %0d", got_wcyc(0), last_acc_cyc + 1); else passed++;
    checks++; if (wr_addr.size() != 1) $display("FAIL bp_nwrites: got %0d exp 1", wr_addr.size()); else passed++;
  endtask

  task automatic test_wrap();
    bit tmo;
    fill_seq(1'b0); clear_log();
    run_cmd(12'hFFF, 12'd2, 0, -1, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) $display("FAIL wrap_timeout: no done"); else passed++;
    checks++; if (wr_addr.size() != 2) $display("FAIL wrap_nwrites: got %0d exp 2", wr_addr.size()); else passed++;
    checks++; if (got_addr(0) !== 12'hFFF) $display("FAIL wrap_addr0: got %h exp fff", got_addr(0)); else passed++;
    checks++; if (got_addr(1) !== 12'h000) $display("FAIL wrap_addr1: got %h exp 000", got_addr(1)); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (got_data(i) !== exp_line(i)) $display("FAIL wrap_din%0d beat %0d: got %h exp %h", i, diff_beat(got_data(i), exp_line(i)),
        got_data(i)[diff_beat(got_data(i), exp_line(i))*IW +: IW], exp_line(i)[diff_beat(got_data(i), exp_line(i))*IW +: IW]); else passed++;
    end
    checks++; if (got_wcyc(1) - got_wcyc(0) != 21) $display("FAIL wrap_spacing: got %0d exp 21", got_wcyc(1) - got_wcyc(0)); else passed++;
    checks++; if (got_dcyc(0) != got_wcyc(1) + 1) $display("FAIL wrap_done_cycle: got %0d exp %0d", got_dcyc(0), got_wcyc(1) + 1); else passed++;
    checks++; if (lines_written !== 13'd2) $display("FAIL wrap_lines: got %0d exp 2", lines_written); else passed++;
    checks++; if (bram_din !== exp_line(1)) $display("FAIL wrap_din_hold: beat %0d differs", diff_beat(bram_din, exp_line(1))); else passed++;
  endtask

  task automatic test_random_multi();
    bit tmo;
    logic [W-1:0] base, ea;
    int len;
    for (int r = 0; r < 2; r++) begin
      fill_seq(1'b0); clear_log();
      base = 12'($urandom);
      len  = $urandom_range(2, 4);
      run_cmd(base, 12'(len), 2, -1, 1'b0, tmo);
      checks++; if (tmo !== 1'b0) $display("FAIL rnd_timeout: no done"); else passed++;
      checks++; if (wr_addr.size() != len) $display("FAIL rnd_nwrites: got %0d exp %0d", wr_addr.size(), len); else passed++;
      for (int i = 0; i < len; i++) begin
        ea = base + 12'(i);
        checks++; if (got_addr(i) !== ea) $display("FAIL rnd_addr%0d: got %h exp %h", i, got_addr(i), ea); else passed++;
        checks++; if (got_data(i) !== exp_line(i)) $display("FAIL rnd_din%0d beat %0d: got %h exp %h", i, diff_beat(got_data(i), exp_line(i)),
          got_data(i)[diff_beat(got_data(i), exp_line(i))*IW +: IW], exp_line(i)[diff_beat(got_data(i), exp_line(i))*IW +: IW]); else passed++;
      end
      checks++; if (lines_written !== 13'(len)) $display("FAIL rnd_lines: got %0d exp %0d", lines_written, len); else passed++;
    end
  endtask

  task automatic test_zero_and_ignored();
    bit tmo;
    fill_seq(1'b0); clear_log();
    run_cmd(12'h123, 12'd0, 0, -1, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) $display("FAIL zero_timeout: no done"); else passed++;
    checks++; if (got_dcyc(0) != start_cyc + 1) $display("FAIL zero_done_cycle: got %0d exp %0d", got_dcyc(0), start_cyc + 1); else passed++;
    checks++; if (en_cnt != 0) $display("FAIL zero_en: got %0d enable cycles exp 0", en_cnt); else passed++;
    checks++; if (acc_cnt != 0) $display("FAIL zero_accepted: got %0d exp 0", acc_cnt); else passed++;
    checks++; if (lines_written !== 13'd0) $display("FAIL zero_lines: got %0d exp 0", lines_written); else passed++;
    fill_seq(1'b0); clear_log();
    run_cmd(12'h100, 12'd1, 0, -1, 1'b1, tmo);
    checks++; if (tmo !== 1'b0) $display("FAIL ign_timeout: no done"); else passed++;
    checks++; if (wr_addr.size() != 1) $display("FAIL ign_nwrites: got %0d exp 1", wr_addr.size()); else passed++;
    checks++; if (got_addr(0) !== 12'h100) $display("FAIL ign_addr: got %h exp 100", got_addr(0)); else passed++;
    checks++; if (got_data(0) !== exp_line(0)) $display("FAIL ign_din: beat %0d differs", diff_beat(got_data(0), exp_line(0))); else passed++;
    checks++; if (lines_written !== 13'd1) $display("FAIL ign_lines: got %0d exp 1", lines_written); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    bit tmo;
    fill_seq(1'b0); clear_log();
    run_cmd(12'h040, 12'd1, 0, 7, 1'b0, tmo);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (en_cnt != 0) $display("FAIL midrst_en: got %0d enable cycles exp 0", en_cnt); else passed++;
    checks++; if (acc_cnt != 7) $display("FAIL midrst_accepted: got %0d exp 7", acc_cnt); else passed++;
    fill_seq(1'b0); clear_log();
    run_cmd(12'h020, 12'd1, 0, -1, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) $display("FAIL midrst_timeout: no done"); else passed++;
    checks++; if (got_addr(0) !== 12'h020) $display("FAIL midrst_addr: got %h exp 020", got_addr(0)); else passed++;
    checks++; if (got_data(0)[IW-1:0] !== seq[0]) $display("FAIL midrst_beat0: got %h exp %h", got_data(0)[IW-1:0], seq[0]); else passed++;
    checks++; if (got_data(0) !== exp_line(0)) $display("FAIL midrst_din: beat %0d differs", diff_beat(got_data(0), exp_line(0))); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    base_address = '0; write_length = '0;
    clear_log();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    test_reset();
    test_single_line();
    test_backpressure();
    test_wrap();
    test_random_multi();
    test_zero_and_ignored();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
